// File: rtl/fetch_sequencer.sv
// Program-counter controller for the instruction-fetch stage: runs a program
// from an entry point until a halt word or the instruction budget is reached.
module fetch_sequencer #(
  parameter logic [15:0] MAX_INS   = 16'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      entry,
  input  logic             stall,
  input  logic             zero,
  input  logic [31:0]      ins,
  input  logic [31:0]      pcp4,
  output logic [31:0]      pc,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  localparam int         CMP_W  = (CNT_W > 16) ? CNT_W : 16;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_pc;
  logic [CNT_W-1:0]   r_retired;
  logic               r_busy;
  logic               r_done;

  logic [5:0]         w_opcode;
  logic [31:0]        w_br_off;
  logic [31:0]        w_next_pc;
  logic [CNT_W-1:0]   w_ret_inc;
  logic               w_is_halt;
  logic               w_budget_hit;

  // Next-PC selection, retire count and halt/budget detection
  always_comb begin
    w_opcode     = ins[31:26];
    w_br_off     = {{14{ins[15]}}, ins[15:0], 2'b00};
    w_ret_inc    = r_retired + CNT_W'(1);
    w_is_halt    = (ins == HALT_WORD);
    // Compare in a common width so narrow counters never truncate the budget
    w_budget_hit = (MAX_INS != 16'd0) && (CMP_W'(w_ret_inc) == CMP_W'(MAX_INS));
    case (w_opcode)
      OP_J: begin
        w_next_pc = {pcp4[31:28], ins[25:0], 2'b00};
      end
      OP_BEQ: begin
        if (zero) begin
          w_next_pc = pcp4 + w_br_off;
        end else begin
          w_next_pc = pcp4;
        end
      end
      default: begin
        w_next_pc = pcp4;
      end
    endcase
  end

  // Sequencer FSM with registered pc, counter and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= 32'd0;
      r_retired <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state   <= S_RUN;
            r_pc      <= {entry[31:2], 2'b00};
            r_retired <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end else begin
            r_state   <= r_state;
            r_pc      <= r_pc;
            r_retired <= r_retired;
            r_busy    <= r_busy;
            r_done    <= r_done;
          end
        end
        S_RUN: begin
          if (stall) begin
            r_state   <= S_RUN;
            r_pc      <= r_pc;
            r_retired <= r_retired;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end else if (w_is_halt) begin
            // pc stays on the halt word, which is not counted
            r_state   <= S_HALT;
            r_pc      <= r_pc;
            r_retired <= r_retired;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else if (w_budget_hit) begin
            r_state   <= S_HALT;
            r_pc      <= w_next_pc;
            r_retired <= w_ret_inc;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_state   <= S_RUN;
            r_pc      <= w_next_pc;
            r_retired <= w_ret_inc;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_pc      <= 32'd0;
          r_retired <= '0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign pc      = r_pc;
  assign busy    = r_busy;
  assign done    = r_done;
  assign retired = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized fetch traffic
// checked every cycle against a behavioural model of the PC controller.
module tb_fetch_sequencer;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int          MAXI = 11;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        zero  = 1'b0;
  logic [31:0] entry = 32'd0;
  logic [31:0] ins   = 32'd0;
  logic [31:0] pcp4  = 32'd0;
  wire  [31:0] pc;
  wire         busy;
  wire         done;
  wire  [15:0] retired;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [15:0] m_ret;
  logic        m_busy;
  logic        m_done;

  fetch_sequencer #(
    .MAX_INS  (16'd11),
    .HALT_WORD(HALT),
    .CNT_W    (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .entry  (entry),
    .stall  (stall),
    .zero   (zero),
    .ins    (ins),
    .pcp4   (pcp4),
    .pc     (pc),
    .busy   (busy),
    .done   (done),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural target: jump keeps the pcp4 region, taken beq adds 4*simm16
  function automatic logic [31:0] ref_next(input logic [31:0] w, input logic [31:0] p4, input logic z);
    int signed imm;
    imm = int'($signed(w[15:0]));
    if (w[31:26] == 6'h02) return {p4[31:28], w[25:0], 2'b00};
    if (w[31:26] == 6'h04 && z) return p4 + 32'(imm * 4);
    return p4;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_ret = 16'd0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      if (start) begin
        m_pc = entry & 32'hFFFF_FFFC; m_ret = 16'd0; m_busy = 1'b1; m_done = 1'b0;
      end
    end else if (stall) begin
      m_pc = m_pc;
    end else if (ins == HALT) begin
      m_busy = 1'b0; m_done = 1'b1;
    end else begin
      m_pc  = ref_next(ins, pcp4, zero);
      m_ret = m_ret + 16'd1;
      if (int'(m_ret) == MAXI) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"},   pc,             m_pc);
    chk({tag, "_busy"}, 32'(busy),      32'(m_busy));
    chk({tag, "_done"}, 32'(done),      32'(m_done));
    chk({tag, "_ret"},  32'(retired),   32'(m_ret));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic seq_in();
    ins = 32'h2000_0001; pcp4 = m_pc + 32'd4; stall = 1'b0; start = 1'b0; zero = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] e);
    entry = e; start = 1'b1; stall = 1'b0; ins = 32'd0;
    cycle("start");
    start = 1'b0;
  endtask

  task automatic force_halt();
    ins = HALT; stall = 1'b0; start = 1'b0;
    cycle("halt");
  endtask

  task automatic mid_reset(input string tag);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #10;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential run up to the budget
    pulse_start(32'd128);
    chk("seq_entry", pc, 32'd128);
    for (int k = 1; k <= 11; k++) begin
      seq_in();
      cycle("seq");
      chk("seq_step", pc, 32'(128 + 4 * k));
    end
    chk("seq_done", 32'(done), 32'd1);
    chk("seq_busy", 32'(busy), 32'd0);
    chk("seq_cnt", 32'(retired), 32'd11);
    for (int k = 0; k < 5; k++) begin
      seq_in();
      cycle("seq_hold");
      chk("seq_hold_pc", pc, 32'd172);
    end

    // Jump
    pulse_start(32'h80);
    ins = 32'h0800_0040; pcp4 = 32'h84;
    cycle("jump");
    chk("jump_pc", pc, 32'h100);
    chk("jump_cnt", 32'(retired), 32'd1);

    // Branches
    force_halt();
    pulse_start(32'h84);
    ins = 32'h1000_FFFF; zero = 1'b1; pcp4 = 32'h88;
    cycle("beq_back");
    chk("beq_back_pc", pc, 32'h84);
    zero = 1'b0;
    cycle("beq_nt");
    chk("beq_nt_pc", pc, 32'h88);
    force_halt();
    pulse_start(32'h84);
    ins = 32'h1000_0003; zero = 1'b1; pcp4 = 32'h88;
    cycle("beq_fwd");
    chk("beq_fwd_pc", pc, 32'h94);
    zero = 1'b0;

    // Stall suppresses the halt check
    stall = 1'b1; ins = HALT;
    for (int k = 0; k < 3; k++) begin
      cycle("stall");
      chk("stall_pc", pc, 32'h94);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    stall = 1'b0;
    cycle("halt_rel");
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_pc", pc, 32'h94);
    chk("halt_cnt", 32'(retired), 32'd1);
    pulse_start(32'h203);
    chk("restart_pc", pc, 32'h200);
    chk("restart_cnt", 32'(retired), 32'd0);

    // Start ignored in RUN, then asynchronous reset mid-run
    force_halt();
    pulse_start(32'h88);
    seq_in(); start = 1'b1; entry = 32'h400;
    cycle("ign_start");
    chk("ign_start_pc", pc, 32'h8C);
    seq_in();
    cycle("pre_rst");
    chk("pre_rst_pc", pc, 32'h90);
    mid_reset("async_rst");
    chk("async_rst_pc", pc, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, m_busy ? 7 : 2) == 0);
      entry = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      zero  = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       ins = HALT;
        1, 2:    ins = {6'h02, 26'($urandom)};
        3, 4:    ins = {6'h04, 10'($urandom), 16'($urandom)};
        default: ins = $urandom;
      endcase
      pcp4 = ($urandom_range(0, 9) == 0) ? $urandom : m_pc + 32'd4;
      cycle("rnd");
      if ($urandom_range(0, 299) == 0) mid_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
